// File: rtl/serie_paralelo_sync.sv
// Purpose : serial-to-parallel byte recovery with comma-based word alignment (HUNT/ALIGN/ACTIVE).
// Latency : one clk_32f edge: the byte whose LSB is sampled at edge k is on data_out after edge k.
// Backpr. : none; the serial stream is never stalled, and each byte is presented for exactly 8 cycles.
//
// Ports:
//   clk_32f   in   1  bit-rate clock, all state moves on its rising edge
//   reset     in   1  synchronous active-high reset
//   data_in   in   1  serial stream, MSB of each byte first
//   data_out  out  8  last byte recovered at a word boundary while locked
//   valid_out out  1  data_out holds a data byte (not the comma, not before lock)
//   active    out  1  locked to the word boundary
//
// Optional feature: define SAP_RESYNC_EN to let a misaligned comma seen while
// locked drop the lock and realign to the new bit offset. Without it the lock
// is sticky until reset and no realignment logic exists.

module serie_paralelo_sync #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  // Lock threshold in the width of the comma counter (LOCK_COUNT is 2..15).
  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  // State registers
  logic [1:0] r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_comma_cnt;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_active;

  // Next-state values
  logic [1:0] w_state_nxt;
  logic [2:0] w_bit_cnt_nxt;
  logic [3:0] w_comma_cnt_nxt;
  logic [7:0] w_data_nxt;
  logic       w_valid_nxt;
  logic       w_active_nxt;

  // The byte window includes the bit being sampled this cycle, so a comma is
  // recognised on the same edge that its LSB arrives.
  logic [7:0] w_window;
  logic       w_comma;
  logic       w_boundary;
  logic [2:0] w_bit_cnt_inc;
  logic [3:0] w_comma_cnt_inc;

  assign w_window        = {r_shift[6:0], data_in};
  assign w_comma         = (w_window == COMMA);
  assign w_boundary      = (r_bit_cnt == 3'd7);
  assign w_bit_cnt_inc   = r_bit_cnt + 3'd1;   // wraps 7 -> 0
  assign w_comma_cnt_inc = r_comma_cnt + 4'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_comma_cnt_nxt = r_comma_cnt;
    w_data_nxt      = r_data;
    w_valid_nxt     = r_valid;
    w_active_nxt    = r_active;

    case (r_state)
      ST_HUNT: begin
        // Search every bit offset; the counter is restarted so that the next
        // boundary lands exactly eight bits after this comma.
        w_valid_nxt  = 1'b0;
        w_active_nxt = 1'b0;
        if (w_comma) begin
          w_bit_cnt_nxt   = 3'd0;
          w_comma_cnt_nxt = 4'd1;
          w_state_nxt     = ST_ALIGN;
        end
      end

      ST_ALIGN: begin
        w_valid_nxt   = 1'b0;
        w_bit_cnt_nxt = w_bit_cnt_inc;
        if (w_boundary) begin
          if (w_comma) begin
            w_comma_cnt_nxt = w_comma_cnt_inc;
            // Lock on the very edge that counts the last required comma.
            if (w_comma_cnt_inc == LOCK_CNT) begin
              w_state_nxt  = ST_ACTIVE;
              w_active_nxt = 1'b1;
            end
          end else begin
            // Any non-comma at a candidate boundary means a false alignment.
            w_comma_cnt_nxt = 4'd0;
            w_state_nxt     = ST_HUNT;
          end
        end
      end

      ST_ACTIVE: begin
        w_bit_cnt_nxt = w_bit_cnt_inc;
        if (w_boundary) begin
          w_data_nxt  = w_window;
          w_valid_nxt = !w_comma;
        end
`ifdef SAP_RESYNC_EN
        else if (w_comma) begin
          // A comma off the current boundary means the stream slipped:
          // drop the lock, keep the last byte, and realign on this offset.
          w_active_nxt    = 1'b0;
          w_valid_nxt     = 1'b0;
          w_bit_cnt_nxt   = 3'd0;
          w_comma_cnt_nxt = 4'd1;
          w_state_nxt     = ST_ALIGN;
        end
`else
        // Lock is sticky: misaligned commas are simply part of the data.
`endif
      end

      default: begin
        // Unused encoding: fall back to a clean search.
        w_state_nxt     = ST_HUNT;
        w_bit_cnt_nxt   = 3'd0;
        w_comma_cnt_nxt = 4'd0;
        w_valid_nxt     = 1'b0;
        w_active_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      // Reset wins over everything, including a partially received byte.
      r_state     <= ST_HUNT;
      r_shift     <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_comma_cnt <= 4'd0;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_window;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_comma_cnt <= w_comma_cnt_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_active    <= w_active_nxt;
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign active    = r_active;

endmodule

// File: tb/tb_serie_paralelo_sync.sv
// Bench for serie_paralelo_sync: scenario tasks with inline checks against
// expectations derived from the byte stream each task constructs.
module tb_serie_paralelo_sync;

  localparam logic [7:0] COMMA = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int n_checks = 0;
  int n_pass   = 0;

  serie_paralelo_sync #(.COMMA(COMMA), .LOCK_COUNT(4)) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  always #5 clk_32f = ~clk_32f;

  // One bit per edge; outputs are looked at 1 ns after the edge.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    data_in = 1'b0;
    repeat (2) @(posedge clk_32f);
    #1;
    reset = 1'b0;
  endtask

  // True when the 16-bit stream {a,b} has no comma at a non-byte offset.
  function automatic bit clean_pair(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] w;
    w = {a, b};
    for (int k = 1; k <= 7; k++)
      if (w[15-k -: 8] == COMMA) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      data_in = 1'($urandom);
      @(posedge clk_32f);
      #1;
      if ({data_out, valid_out, active} !== 10'h000)
        $display("FAIL reset_hold: got data=%h valid=%b active=%b, expected 00/0/0", data_out, valid_out, active);
      else n_pass++;
      n_checks++;
    end
    reset = 1'b0;
  endtask

  task automatic test_lock_aligned();
    logic [7:0] c;
    int edge_no;
    c = COMMA;
    do_reset();
    edge_no = 0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(c[i]);
        edge_no++;
        if ({active, valid_out} !== {(edge_no == 32), 1'b0})
          $display("FAIL lock_edge%0d: got active=%b valid=%b, expected active=%b valid=0", edge_no, active, valid_out, (edge_no == 32));
        else n_pass++;
        n_checks++;
      end
    end
    send_byte(COMMA);
    if ({data_out, valid_out, active} !== {COMMA, 1'b0, 1'b1})
      $display("FAIL lock_comma_out: got data=%h valid=%b active=%b, expected %h/0/1", data_out, valid_out, active, COMMA);
    else n_pass++;
    n_checks++;
  endtask

  // Continues from the locked state left by test_lock_aligned.
  task automatic test_data();
    logic [7:0] seq [13];
    logic [7:0] b;
    logic [7:0] exp_data;
    logic       exp_valid;
    bit         ok;
    seq[0] = 8'hFF; seq[1] = 8'hEE; seq[2] = 8'hDD; seq[3] = 8'hCC;
    seq[12] = COMMA;
    do begin
      for (int i = 4; i < 12; i++) seq[i] = 8'($urandom);
      ok = 1'b1;
      for (int i = 3; i < 12; i++) if (!clean_pair(seq[i], seq[i+1])) ok = 1'b0;
    end while (!ok);
    exp_data  = COMMA;
    exp_valid = 1'b0;
    for (int n = 0; n < 13; n++) begin
      b = seq[n];
      for (int i = 7; i >= 0; i--) begin
        send_bit(b[i]);
        if (i == 0) begin
          exp_data  = b;
          exp_valid = (b != COMMA);
        end
        if ({data_out, valid_out, active} !== {exp_data, exp_valid, 1'b1})
          $display("FAIL data_byte%0d_bit%0d: got data=%h valid=%b active=%b, expected %h/%b/1", n, i, data_out, valid_out, active, exp_data, exp_valid);
        else n_pass++;
        n_checks++;
      end
    end
  endtask

  task automatic test_offset();
    int nbits;
    for (int t = 0; t < 3; t++) begin
      nbits = (t == 0) ? 3 : $urandom_range(1, 7);
      do_reset();
      for (int i = 0; i < nbits; i++) send_bit(1'($urandom));
      repeat (3) send_byte(COMMA);
      if (active !== 1'b0)
        $display("FAIL offset%0d_prelock: got active=%b, expected 0", nbits, active);
      else n_pass++;
      n_checks++;
      send_byte(COMMA);
      if ({active, valid_out} !== 2'b10)
        $display("FAIL offset%0d_lock: got active=%b valid=%b, expected 1/0", nbits, active, valid_out);
      else n_pass++;
      n_checks++;
      send_byte(8'h77);
      if ({data_out, valid_out} !== {8'h77, 1'b1})
        $display("FAIL offset%0d_data: got data=%h valid=%b, expected 77/1", nbits, data_out, valid_out);
      else n_pass++;
      n_checks++;
    end
  endtask

  task automatic test_abort();
    do_reset();
    repeat (3) send_byte(COMMA);
    send_byte(8'h12);
    if ({data_out, valid_out, active} !== 10'h000)
      $display("FAIL abort_after12: got data=%h valid=%b active=%b, expected 00/0/0", data_out, valid_out, active);
    else n_pass++;
    n_checks++;
    for (int n = 1; n <= 4; n++) begin
      send_byte(COMMA);
      if (active !== (n == 4))
        $display("FAIL abort_relock%0d: got active=%b, expected %b", n, active, (n == 4));
      else n_pass++;
      n_checks++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] aa;
    aa = 8'hAA;
    do_reset();
    repeat (4) send_byte(COMMA);
    send_byte(8'h5A);
    if ({data_out, valid_out, active} !== {8'h5A, 1'b1, 1'b1})
      $display("FAIL rstmid_pre: got data=%h valid=%b active=%b, expected 5a/1/1", data_out, valid_out, active);
    else n_pass++;
    n_checks++;
    for (int i = 7; i >= 4; i--) send_bit(aa[i]);
    reset = 1'b1;
    send_bit(aa[3]);
    reset = 1'b0;
    if ({data_out, valid_out, active} !== 10'h000)
      $display("FAIL rstmid_clear: got data=%h valid=%b active=%b, expected 00/0/0", data_out, valid_out, active);
    else n_pass++;
    n_checks++;
    for (int n = 1; n <= 4; n++) begin
      send_byte(COMMA);
      if (active !== (n == 4))
        $display("FAIL rstmid_relock%0d: got active=%b, expected %b", n, active, (n == 4));
      else n_pass++;
      n_checks++;
    end
  endtask

  task automatic test_resync();
    logic [7:0] c;
    logic [1:0] s;
    logic [7:0] old_win;
    logic [7:0] exp_last;
    bit         resync;
`ifdef SAP_RESYNC_EN
    resync = 1'b1;
`else
    resync = 1'b0;
`endif
    c = COMMA;
    s = 2'($urandom);
    do_reset();
    repeat (4) send_byte(COMMA);
    send_byte(8'h55);
    send_bit(s[1]);
    send_bit(s[0]);
    for (int i = 7; i >= 2; i--) send_bit(c[i]);
    // Old boundary falls six bits into the slipped comma.
    old_win = {s, c[7:2]};
    if ({data_out, valid_out, active} !== {old_win, 1'b1, 1'b1})
      $display("FAIL slip_oldbound: got data=%h valid=%b active=%b, expected %h/1/1", data_out, valid_out, active, old_win);
    else n_pass++;
    n_checks++;
    send_bit(c[1]);
    send_bit(c[0]);
    if ({active, valid_out, data_out} !== {!resync, !resync, old_win})
      $display("FAIL slip_match: got active=%b valid=%b data=%h, expected %b/%b/%h", active, valid_out, data_out, !resync, !resync, old_win);
    else n_pass++;
    n_checks++;
    for (int n = 1; n <= 3; n++) begin
      send_byte(COMMA);
      if (active !== (!resync || n == 3))
        $display("FAIL slip_relock%0d: got active=%b, expected %b", n, active, (!resync || n == 3));
      else n_pass++;
      n_checks++;
    end
    // Locked at the new offset the last byte is still the old one; without
    // realignment the old boundary keeps slicing {comma[1:0], comma[7:2]}.
    exp_last = resync ? old_win : {c[1:0], c[7:2]};
    if ({data_out, valid_out} !== {exp_last, !resync})
      $display("FAIL slip_held: got data=%h valid=%b, expected %h/%b", data_out, valid_out, exp_last, !resync);
    else n_pass++;
    n_checks++;
    if (resync) begin
      send_byte(8'h33);
      if ({data_out, valid_out, active} !== {8'h33, 1'b1, 1'b1})
        $display("FAIL slip_data: got data=%h valid=%b active=%b, expected 33/1/1", data_out, valid_out, active);
      else n_pass++;
      n_checks++;
    end
  endtask

  initial begin
    reset   = 1'b1;
    data_in = 1'b0;
    test_reset();
    test_lock_aligned();
    test_data();
    test_offset();
    test_abort();
    test_reset_mid();
    test_resync();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serie_paralelo_sync.md
SERIE_PARALELO_SYNC -- requirements
Module: serie_paralelo_sync

Interface
REQ-001 clk_32f  input  1  Single bit-rate clock; all state updates on its rising edge.
REQ-002 reset  input  1  Synchronous, active-high reset, sampled on rising clk_32f.
REQ-003 data_in  input  1  Serial bit stream, MSB of each byte first, one bit per clk_32f cycle.
REQ-004 data_out  output  8  Last recovered byte; registered; held until the next word boundary.
REQ-005 valid_out  output  1  High when data_out holds a data byte; low for idle (0xBC) or before lock.
REQ-006 active  output  1  High while the block is locked to the word boundary (state ACTIVE).
REQ-007 Parameter COMMA, default 8'hBC: idle/alignment symbol.
REQ-008 Parameter LOCK_COUNT, default 4: number of consecutive aligned commas needed to lock; range 2..15.

Function
REQ-009 The block SHALL shift data_in into an 8-bit register each cycle; the window is {shift[6:0], data_in}.
REQ-010 The block SHALL implement the FSM states HUNT, ALIGN and ACTIVE, plus a 3-bit bit counter and a 4-bit comma counter.
REQ-011 In HUNT, the block SHALL compare the window with COMMA every cycle, at any bit offset.
REQ-012 On a match in HUNT, the block SHALL clear the bit counter, set the comma counter to 1 and go to ALIGN.
REQ-013 In ALIGN and ACTIVE, the bit counter SHALL increment modulo 8.
REQ-014 A word boundary is the cycle in which the bit counter equals 7.
REQ-015 At a boundary in ALIGN with window==COMMA, the comma counter SHALL increment.
REQ-016 When the comma counter reaches LOCK_COUNT, the block SHALL enter ACTIVE and set active to 1 on the same edge.
REQ-017 At a boundary in ALIGN with window!=COMMA, the block SHALL return to HUNT and clear the comma counter.
REQ-018 At each boundary in ACTIVE, the block SHALL load data_out with the window.
REQ-019 At each boundary in ACTIVE, valid_out SHALL become (window!=COMMA).
REQ-020 Latency SHALL be one edge: a byte whose LSB is sampled at edge k appears on data_out after edge k.
REQ-021 data_out and valid_out SHALL NOT change between boundaries, and SHALL NOT change in HUNT or ALIGN (valid_out forced 0 there).
REQ-022 ACTIVE SHALL be exited only by reset, or as described in REQ-026.
REQ-023 If reset is asserted mid-word, it SHALL take priority, abandon the partial byte and restart in HUNT.

Reset
REQ-024 While reset=1: state=HUNT, shift register=0, bit counter=0, comma counter=0, data_out=8'h00, valid_out=0, active=0.
REQ-025 The first bit sampled after the edge on which reset is released SHALL be the first bit shifted in.

Configuration
REQ-026 Macro SAP_RESYNC_EN, when defined: in ACTIVE, a window==COMMA at a non-boundary cycle SHALL, on that edge:
- deassert active and valid_out (data_out held);
- clear the bit counter and set the comma counter to 1;
- enter ALIGN (realign to the new offset).
REQ-027 Without SAP_RESYNC_EN, ACTIVE SHALL be sticky until reset, misaligned commas SHALL be ignored, and no resync logic SHALL be compiled in.

Verification
REQ-028 Reset, then 4x 0xBC sent aligned -> active=1 on the edge of the 32nd bit; valid_out=0; data_out=0xBC after that boundary.
REQ-029 Lock, then bytes 0xFF, 0xEE, 0xDD, 0xCC -> data_out shows each byte one edge after its LSB, held 8 cycles; valid_out=1; a following 0xBC drives valid_out=0.
REQ-030 3 random bits, then 4x 0xBC, then 0x77 -> HUNT finds the offset; active=1 after the 4th comma; data_out=0x77 with valid_out=1.
REQ-031 3x 0xBC, then 0x12 -> return to HUNT; active stays 0; the next 4x 0xBC lock correctly.
REQ-032 Lock, then reset pulsed at bit 4 of a 0xAA byte -> all outputs 0 on the next edge; a relock needs 4 fresh commas.
REQ-033 SAP_RESYNC_EN defined: lock, slip the stream by 2 bits, send 0xBC -> active=0 at the misaligned match; active=1 again after 3 more aligned commas. With the macro undefined, the same stimulus leaves active=1.
